// File: rtl/intersection_scheduler.sv
// Two-road intersection controller with a pedestrian phase. Moore FSM with
// registered lamp outputs, a shared phase counter and a tick divider.
module intersection_scheduler #(
    parameter int SIM       = 0,
    parameter int TICK_DIV  = 50000000,
    parameter int MIN_GREEN = 10,
    parameter int MAX_GREEN = 30,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int PED_T     = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SensorMain,
    input  logic       SensorSide,
    input  logic       PedReq,
    output logic       MainGreen,
    output logic       MainYellow,
    output logic       MainRed,
    output logic       SideGreen,
    output logic       SideYellow,
    output logic       SideRed,
    output logic       PedGreen,
    output logic       PedRed,
    output logic       PedWait,
    output logic [2:0] Phase
);

    typedef enum logic [2:0] {
        MAIN_G   = 3'd0,
        MAIN_Y   = 3'd1,
        CLEAR_A  = 3'd2,
        SIDE_G   = 3'd3,
        SIDE_Y   = 3'd4,
        CLEAR_B  = 3'd5,
        PED_WALK = 3'd6
    } state_t;

    localparam logic [7:0] MIN_M1    = 8'(MIN_GREEN - 1);
    localparam logic [7:0] MAX_M1    = 8'(MAX_GREEN - 1);
    localparam logic [7:0] YELLOW_M1 = 8'(YELLOW_T - 1);
    localparam logic [7:0] ALLRED_M1 = 8'(ALLRED_T - 1);
    localparam logic [7:0] PED_M1    = 8'(PED_T - 1);

    // Lamp vector order: {MG, MY, MR, SG, SY, SR, PG, PR}
    function automatic logic [7:0] lamps_of(input state_t s);
        logic mg, my, sg, sy, pg;
        mg = (s == MAIN_G);
        my = (s == MAIN_Y);
        sg = (s == SIDE_G);
        sy = (s == SIDE_Y);
        pg = (s == PED_WALK);
        return {mg, my, ~(mg | my), sg, sy, ~(sg | sy), pg, ~pg};
    endfunction

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       side_req_q, side_req_d;
    logic       ped_req_q, ped_req_d;
    logic       from_ped_q, from_ped_d;
    logic [7:0] lamps_q;
    logic       tick;
    logic       enter;
    logic       sensor_main_unused;

    // Main-road presence does not influence sequencing.
    assign sensor_main_unused = SensorMain;

    generate
        if (SIM != 0) begin : g_sim_tick
            assign tick = 1'b1;
        end else begin : g_div_tick
            localparam int DIV_W = $clog2(TICK_DIV);
            localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
            logic [DIV_W-1:0] div_q;

            // Free-running: never realigned to state changes.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    div_q <= '0;
                end else if (div_q == DIV_LAST) begin
                    div_q <= '0;
                end else begin
                    div_q <= div_q + 1'b1;
                end
            end

            assign tick = (div_q == DIV_LAST);
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            MAIN_G: begin
                if (tick && cnt_q >= MIN_M1 && (side_req_q || ped_req_q)) begin
                    state_d = MAIN_Y;
                end
            end
            MAIN_Y: begin
                if (tick && cnt_q == YELLOW_M1) begin
                    state_d = CLEAR_A;
                end
            end
            CLEAR_A: begin
                if (tick && cnt_q == ALLRED_M1) begin
                    if (ped_req_q) begin
                        state_d = PED_WALK;
                    end else if (side_req_q) begin
                        state_d = SIDE_G;
                    end else begin
                        state_d = MAIN_G;
                    end
                end
            end
            SIDE_G: begin
                if (tick && ((cnt_q >= MIN_M1 && !SensorSide) || cnt_q >= MAX_M1)) begin
                    state_d = SIDE_Y;
                end
            end
            SIDE_Y: begin
                if (tick && cnt_q == YELLOW_M1) begin
                    state_d = CLEAR_B;
                end
            end
            PED_WALK: begin
                if (tick && cnt_q == PED_M1) begin
                    state_d = CLEAR_B;
                end
            end
            CLEAR_B: begin
                // from_ped steers the second half so each party is served once.
                if (tick && cnt_q == ALLRED_M1) begin
                    if (from_ped_q && side_req_q) begin
                        state_d = SIDE_G;
                    end else if (!from_ped_q && ped_req_q) begin
                        state_d = PED_WALK;
                    end else begin
                        state_d = MAIN_G;
                    end
                end
            end
            default: state_d = MAIN_G;
        endcase

        enter = (state_d != state_q);

        if (enter) begin
            cnt_d = '0;
        end else if (tick && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end

        if (enter && state_d == SIDE_G) begin
            side_req_d = 1'b0;
        end else begin
            side_req_d = side_req_q | (SensorSide & (state_q != SIDE_G));
        end

        if (enter && state_d == PED_WALK) begin
            ped_req_d = 1'b0;
        end else begin
            ped_req_d = ped_req_q | (PedReq & (state_q != PED_WALK));
        end

        from_ped_d = from_ped_q;
        if (enter && state_d == CLEAR_B) begin
            from_ped_d = (state_q == PED_WALK);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= MAIN_G;
            cnt_q      <= '0;
            side_req_q <= 1'b0;
            ped_req_q  <= 1'b0;
            from_ped_q <= 1'b0;
            lamps_q    <= lamps_of(MAIN_G);
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            side_req_q <= side_req_d;
            ped_req_q  <= ped_req_d;
            from_ped_q <= from_ped_d;
            lamps_q    <= lamps_of(state_d);
        end
    end

    assign {MainGreen, MainYellow, MainRed,
            SideGreen, SideYellow, SideRed,
            PedGreen, PedRed} = lamps_q;
    assign PedWait = ped_req_q;
    assign Phase   = state_q;

endmodule
